// File: rtl/systolic_pe_os.sv
// Output-stationary systolic PE: pipelined MAC, tile FSM, result drain chain.
// Optional macro SYSTOLIC_PE_SAT_EN: saturating accumulate plus sat_out port.
module systolic_pe_os #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic                     a_vld_in,
    input  logic                     a_clr_in,
    input  logic                     a_last_in,
    input  logic signed [DATA_W-1:0] w_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic                     a_vld_out,
    output logic                     a_clr_out,
    output logic                     a_last_out,
    output logic signed [DATA_W-1:0] w_out,
    input  logic                     drain_shift,
    input  logic signed [ACC_W-1:0]  drain_in,
    input  logic                     drain_vld_in,
    output logic signed [ACC_W-1:0]  drain_out,
    output logic                     drain_vld_out,
    input  logic                     err_clr,
    output logic                     err
`ifdef SYSTOLIC_PE_SAT_EN
    ,
    output logic                     sat_out
`endif
);

    if (ACC_W < 2 * DATA_W) begin : g_bad_width
        $error("systolic_pe_os: ACC_W must be >= 2*DATA_W");
    end

    typedef enum logic {
        S_IDLE,
        S_ACC
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;

    logic signed [DATA_W-1:0]        r_a;
    logic signed [DATA_W-1:0]        r_w;
    logic                            r_a_vld;
    logic                            r_a_clr;
    logic                            r_a_last;

    logic signed [2*DATA_W-1:0]      w_prod;
    logic signed [ACC_W-1:0]         r_prod;
    logic                            r_p_vld;
    logic                            r_p_clr;
    logic                            r_p_last;

    logic signed [ACC_W-1:0]         r_acc;
    logic signed [ACC_W-1:0]         w_base;
    logic signed [ACC_W-1:0]         w_sum;

    logic signed [ACC_W-1:0]         r_res;
    logic                            r_res_vld;
    logic                            r_err;

    logic                            w_zero_acc;
    logic                            w_capture;
    logic                            w_proto_err;
    logic                            w_overrun;
    logic                            w_err_set;

    assign w_prod = a_in * w_in;

    // Neighbour pass-through registers, unconditional every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_w      <= '0;
            r_a_vld  <= 1'b0;
            r_a_clr  <= 1'b0;
            r_a_last <= 1'b0;
        end else begin
            r_a      <= a_in;
            r_w      <= w_in;
            r_a_vld  <= a_vld_in;
            r_a_clr  <= a_clr_in;
            r_a_last <= a_last_in;
        end
    end

    assign a_out      = r_a;
    assign w_out      = r_w;
    assign a_vld_out  = r_a_vld;
    assign a_clr_out  = r_a_clr;
    assign a_last_out = r_a_last;

    // Stage 1: registered product, tile markers gated by valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod   <= '0;
            r_p_vld  <= 1'b0;
            r_p_clr  <= 1'b0;
            r_p_last <= 1'b0;
        end else begin
            r_prod   <= ACC_W'(w_prod);
            r_p_vld  <= a_vld_in;
            r_p_clr  <= a_vld_in & a_clr_in;
            r_p_last <= a_vld_in & a_last_in;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: only valid beats move the tile protocol
    always_comb begin
        w_state_nxt = r_state;
        if (r_p_vld) begin
            w_state_nxt = r_p_last ? S_IDLE : S_ACC;
        end
    end

    // FSM outputs: accumulator restart, capture, protocol error
    always_comb begin
        w_zero_acc  = 1'b1;
        w_proto_err = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_zero_acc  = 1'b1;
                w_proto_err = r_p_vld & ~r_p_clr;
            end
            S_ACC: begin
                w_zero_acc  = r_p_clr;
                w_proto_err = r_p_vld & r_p_clr;
            end
            default: begin
                w_zero_acc  = 1'b1;
                w_proto_err = 1'b0;
            end
        endcase
        w_capture = r_p_vld & r_p_last;
    end

    assign w_base = w_zero_acc ? '0 : r_acc;

`ifdef SYSTOLIC_PE_SAT_EN
    logic signed [ACC_W:0]           w_sum_ext;
    logic                            w_ovf;
    logic                            r_sat;

    assign w_sum_ext = {w_base[ACC_W-1], w_base}
                     + {r_prod[ACC_W-1], r_prod};
    assign w_ovf     = w_sum_ext[ACC_W] ^ w_sum_ext[ACC_W-1];

    // Clamp toward the true sign of the widened sum on overflow
    always_comb begin
        w_sum = w_sum_ext[ACC_W-1:0];
        if (w_ovf) begin
            w_sum = w_sum_ext[ACC_W]
                  ? {1'b1, {(ACC_W-1){1'b0}}}
                  : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // One-cycle flag for every beat that clamped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else begin
            r_sat <= r_p_vld & w_ovf;
        end
    end

    assign sat_out = r_sat;
`else
    assign w_sum = w_base + r_prod;
`endif

    // Stage 2: accumulate in place on valid beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (r_p_vld) begin
            r_acc <= w_sum;
        end
    end

    // Result register: capture has priority over the drain shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res     <= '0;
            r_res_vld <= 1'b0;
        end else if (w_capture) begin
            r_res     <= w_sum;
            r_res_vld <= 1'b1;
        end else if (drain_shift) begin
            r_res     <= drain_in;
            r_res_vld <= drain_vld_in;
        end
    end

    assign drain_out     = r_res;
    assign drain_vld_out = r_res_vld;

    assign w_overrun = w_capture & r_res_vld & ~drain_shift;
    assign w_err_set = w_proto_err | w_overrun;

    // Sticky error; a new error beats a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;

endmodule
